// File: rtl/ub_pkg.sv
// Shared types for the unified-buffer write packer.
// Word bundle, FSM states and default geometry.
package ub_pkg;

  localparam int UB_LANES      = 4;
  localparam int UB_ADDR_W     = 8;
  localparam int UB_CNT_W      = 16;
  localparam int UB_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [UB_LANES*8-1:0] data;
    logic [UB_LANES-1:0]   be;
    logic [UB_ADDR_W-1:0]  addr;
  } ub_word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } pk_state_e;

endpackage

// File: rtl/ub_word_fifo.sv
// First-word fall-through FIFO of packed UB words.
// A push while full is taken only if a pop frees a slot that cycle.
module ub_word_fifo
  import ub_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  ub_word_t wr_word,
  input  logic     pop,
  output ub_word_t rd_word,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  ub_word_t       mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic [AW:0]    cnt;
  logic           wr_en;
  logic           rd_en;

  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Head is forced to zero while empty so idle outputs read as 0.
  assign rd_word = empty ? '0 : mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_word;
        wp      <= wp + AW'(1);
      end
      if (rd_en) rp <= rp + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ub_write_packer.sv
// Packs the int8 activation stream into LANES-wide UB words
// and writes them to consecutive addresses from a base.
module ub_write_packer
  import ub_pkg::*;
#(
  parameter int LANES      = UB_LANES,
  parameter int ADDR_W     = UB_ADDR_W,
  parameter int CNT_W      = UB_CNT_W,
  parameter int FIFO_DEPTH = UB_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic [ADDR_W-1:0]  cfg_base_addr,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic               valid_in,
  input  logic [7:0]         data_in,
  output logic               ub_wr_req,
  output logic [ADDR_W-1:0]  ub_wr_addr,
  output logic [LANES*8-1:0] ub_wr_data,
  output logic [LANES-1:0]   ub_wr_be,
  input  logic               ub_wr_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int LW = $clog2(LANES);

  pk_state_e          state_q;
  pk_state_e          state_d;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  word_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   elem_q;
  logic [LW-1:0]      lane_q;
  logic [LANES*8-1:0] ldata_q;
  logic [LANES-1:0]   lbe_q;
  logic [LANES*8-1:0] ldata_d;
  logic [LANES-1:0]   lbe_d;
  logic               push_q;
  ub_word_t           pword_q;
  ub_word_t           head;
  logic               start_ok;
  logic               take;
  logic               last;
  logic               complete;
  logic               pop;
  logic               full;
  logic               empty;
  logic               drop;

  assign start_ok = cfg_start && state_q == IDLE;
  assign take     = state_q == RUN && valid_in && elem_q != count_q;
  assign last     = take && (elem_q + CNT_W'(1) == count_q);
  assign complete = take && (lane_q == LW'(LANES-1) || last);
  assign pop      = !empty && ub_wr_ready;
  assign drop     = push_q && full && !pop;

  always_comb begin
    ldata_d = ldata_q;
    lbe_d   = lbe_q;
    if (take) begin
      ldata_d[lane_q*8 +: 8] = data_in;
      lbe_d[lane_q]          = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_start) state_d = (cfg_count == '0) ? DONE : RUN;
      RUN:     if (last) state_d = DRAIN;
      DRAIN:   if (!push_q && empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      word_q   <= '0;
      count_q  <= '0;
      elem_q   <= '0;
      lane_q   <= '0;
      ldata_q  <= '0;
      lbe_q    <= '0;
      push_q   <= 1'b0;
      pword_q  <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      push_q  <= complete;
      if (complete) begin
        pword_q <= '{data: ldata_d, be: lbe_d, addr: base_q + word_q};
      end
      if (start_ok) begin
        base_q  <= cfg_base_addr;
        count_q <= cfg_count;
        word_q  <= '0;
        elem_q  <= '0;
        lane_q  <= '0;
        ldata_q <= '0;
        lbe_q   <= '0;
      end else if (take) begin
        elem_q <= elem_q + CNT_W'(1);
        if (complete) begin
          lane_q  <= '0;
          ldata_q <= '0;
          lbe_q   <= '0;
          word_q  <= word_q + ADDR_W'(1);
        end else begin
          lane_q  <= lane_q + LW'(1);
          ldata_q <= ldata_d;
          lbe_q   <= lbe_d;
        end
      end
      // A start wins over a stray element in the same cycle.
      if (start_ok) overflow <= 1'b0;
      else if ((valid_in && !take) || drop) overflow <= 1'b1;
    end
  end

  ub_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_q),
    .wr_word (pword_q),
    .pop     (pop),
    .rd_word (head),
    .full    (full),
    .empty   (empty)
  );

  assign ub_wr_req  = !empty;
  assign ub_wr_addr = head.addr;
  assign ub_wr_data = head.data;
  assign ub_wr_be   = head.be;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;

endmodule

// File: tb/tb_ub_write_packer.sv
// Directed bench for ub_write_packer: packing, stalls,
// FIFO overflow, address wrap, empty jobs and mid-job reset.
module tb_ub_write_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [7:0]  cfg_base_addr;
  logic [15:0] cfg_count;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        ub_wr_req;
  logic [7:0]  ub_wr_addr;
  logic [31:0] ub_wr_data;
  logic [3:0]  ub_wr_be;
  logic        ub_wr_ready;
  logic        busy;
  logic        done;
  logic        overflow;

  int          nvec = 0;
  int          nerr = 0;
  int          done_cnt = 0;
  logic [7:0]  la[$];
  logic [31:0] ld[$];
  logic [3:0]  lb[$];

  ub_write_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_count     (cfg_count),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .ub_wr_req     (ub_wr_req),
    .ub_wr_addr    (ub_wr_addr),
    .ub_wr_data    (ub_wr_data),
    .ub_wr_be      (ub_wr_be),
    .ub_wr_ready   (ub_wr_ready),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (ub_wr_req && ub_wr_ready) begin
        la.push_back(ub_wr_addr);
        ld.push_back(ub_wr_data);
        lb.push_back(ub_wr_be);
      end
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    la.delete();
    ld.delete();
    lb.delete();
    done_cnt = 0;
  endtask

  task automatic start(input logic [7:0] a, input logic [15:0] n);
    @(negedge clk);
    cfg_start     = 1'b1;
    cfg_base_addr = a;
    cfg_count     = n;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    valid_in = 1'b1;
    data_in  = b;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
    gap(3);
  endtask

  task automatic check_wr(input string tag, input int i, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    check({tag, "_addr"}, 32'(la[i]), 32'(a));
    check({tag, "_data"}, ld[i], d);
    check({tag, "_be"}, 32'(lb[i]), 32'(be));
  endtask

  initial begin
    rst_n         = 1'b0;
    cfg_start     = 1'b0;
    cfg_base_addr = '0;
    cfg_count     = '0;
    valid_in      = 1'b0;
    data_in       = '0;
    ub_wr_ready   = 1'b1;
    gap(2);
    check("rst_req", 32'(ub_wr_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", ub_wr_data, 32'd0);
    rst_n = 1'b1;
    gap(1);

    // back-to-back full words
    clear_log();
    start(8'h10, 16'd8);
    check("t1_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 8; i++) send(8'(i));
    wait_done("t1_done", 30);
    check("t1_nwr", 32'(la.size()), 32'd2);
    check_wr("t1_w0", 0, 8'h10, 32'h04030201, 4'hF);
    check_wr("t1_w1", 1, 8'h11, 32'h08070605, 4'hF);
    check("t1_ndone", 32'(done_cnt), 32'd1);
    check("t1_ovf", 32'(overflow), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // partial last word with valid gaps
    clear_log();
    start(8'h20, 16'd6);
    for (int i = 1; i <= 6; i++) begin
      gap($urandom_range(0, 3));
      send(8'(i));
    end
    wait_done("t2_done", 30);
    check("t2_nwr", 32'(la.size()), 32'd2);
    check_wr("t2_w0", 0, 8'h20, 32'h04030201, 4'hF);
    check_wr("t2_w1", 1, 8'h21, 32'h00000605, 4'h3);
    check("t2_ovf", 32'(overflow), 32'd0);

    // write stall holds the head stable
    clear_log();
    ub_wr_ready = 1'b0;
    start(8'h30, 16'd8);
    for (int i = 1; i <= 8; i++) send(8'(i));
    check("t3_req", 32'(ub_wr_req), 32'd1);
    check("t3_addr", 32'(ub_wr_addr), 32'h30);
    check("t3_data", ub_wr_data, 32'h04030201);
    check("t3_be", 32'(ub_wr_be), 32'hF);
    gap(2);
    check("t3_req2", 32'(ub_wr_req), 32'd1);
    check("t3_addr2", 32'(ub_wr_addr), 32'h30);
    check("t3_data2", ub_wr_data, 32'h04030201);
    check("t3_nodone", 32'(done), 32'd0);
    ub_wr_ready = 1'b1;
    wait_done("t3_done", 30);
    check("t3_nwr", 32'(la.size()), 32'd2);
    check_wr("t3_w0", 0, 8'h30, 32'h04030201, 4'hF);
    check_wr("t3_w1", 1, 8'h31, 32'h08070605, 4'hF);
    check("t3_ndone", 32'(done_cnt), 32'd1);
    check("t3_ovf", 32'(overflow), 32'd0);

    // FIFO overflow: 6 words into a 4-entry FIFO with no drain
    clear_log();
    ub_wr_ready = 1'b0;
    start(8'h40, 16'd24);
    for (int i = 1; i <= 24; i++) send(8'(i));
    gap(3);
    check("t4_ovf", 32'(overflow), 32'd1);
    ub_wr_ready = 1'b1;
    wait_done("t4_done", 30);
    check("t4_nwr", 32'(la.size()), 32'd4);
    check_wr("t4_w0", 0, 8'h40, 32'h04030201, 4'hF);
    check_wr("t4_w1", 1, 8'h41, 32'h08070605, 4'hF);
    check_wr("t4_w2", 2, 8'h42, 32'h0C0B0A09, 4'hF);
    check_wr("t4_w3", 3, 8'h43, 32'h100F0E0D, 4'hF);
    check("t4_ndone", 32'(done_cnt), 32'd1);

    // empty job clears overflow and finishes at once
    clear_log();
    start(8'h50, 16'd0);
    check("t5_zdone", 32'(done), 32'd1);
    check("t5_zovf", 32'(overflow), 32'd0);
    gap(1);
    check("t5_zdone_end", 32'(done), 32'd0);
    check("t5_zbusy", 32'(busy), 32'd0);
    gap(3);
    check("t5_znwr", 32'(la.size()), 32'd0);
    check("t5_zndone", 32'(done_cnt), 32'd1);

    // address wrap
    clear_log();
    start(8'hFF, 16'd8);
    for (int i = 1; i <= 8; i++) send(8'(8'h10 + i));
    wait_done("t5_done", 30);
    check("t5_nwr", 32'(la.size()), 32'd2);
    check_wr("t5_w0", 0, 8'hFF, 32'h14131211, 4'hF);
    check_wr("t5_w1", 1, 8'h00, 32'h18171615, 4'hF);

    // reset in the middle of a stalled job
    ub_wr_ready = 1'b0;
    start(8'h60, 16'd8);
    for (int i = 1; i <= 5; i++) send(8'(i));
    gap(2);
    check("t6_pre_req", 32'(ub_wr_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_req", 32'(ub_wr_req), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    gap(2);
    rst_n = 1'b1;
    ub_wr_ready = 1'b1;
    clear_log();
    gap(2);
    check("t6_idle_req", 32'(ub_wr_req), 32'd0);
    start(8'h10, 16'd8);
    for (int i = 1; i <= 8; i++) send(8'(i));
    wait_done("t6_done2", 30);
    check("t6_nwr", 32'(la.size()), 32'd2);
    check_wr("t6_w0", 0, 8'h10, 32'h04030201, 4'hF);
    check_wr("t6_w1", 1, 8'h11, 32'h08070605, 4'hF);
    check("t6_ovf2", 32'(overflow), 32'd0);
    send(8'hAA);
    check("t6_stray_ovf", 32'(overflow), 32'd1);
    check("t6_stray_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
